// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_arbiter
// Purpose : Round-robin arbiter that applies single-cycle JK pulses to a shared
//           cell bank and returns each cell's settled q value.
// Revision: 1.0 - initial release
// ============================================================================

module jk_bank_arbiter #(
  parameter int NREQ       = 2,
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [IDX_W*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_q,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      jk_j,
  output logic [WIDTH-1:0]      jk_k,
  input  logic [WIDTH-1:0]      jk_q
);

  localparam int                 c_PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int                 c_CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W:0]     c_WIDTH    = (IDX_W + 1)'(WIDTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DRIVE  = 2'd1;
  localparam logic [1:0] c_SETTLE = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   r_jk_j;
  logic [WIDTH-1:0]   r_jk_k;
  logic [NREQ-1:0]    r_rsp_valid;
  logic               r_rsp_q;
  logic               r_rsp_err;
  logic               r_busy;

  logic               w_found;
  logic               w_hs;
  logic [c_PTR_W-1:0] w_gnt;
  logic [c_PTR_W-1:0] w_ptr_nxt;
  logic [1:0]         w_gnt_op;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_err;
  logic               w_q_sel;
  logic               w_rsp_fire;

  logic [WIDTH-1:0]   w_jk_j_nxt;
  logic [WIDTH-1:0]   w_jk_k_nxt;
  logic [NREQ-1:0]    w_rsp_valid_nxt;
  logic               w_rsp_q_nxt;
  logic               w_rsp_err_nxt;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt     = '0;
    w_gnt_op  = '0;
    w_gnt_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!w_found && req_valid[(int'(r_ptr) + off) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = c_PTR_W'((int'(r_ptr) + off) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == c_PTR_W'(i)) begin
        w_gnt_op  = req_op[2*i +: 2];
        w_gnt_idx = req_idx[IDX_W*i +: IDX_W];
      end
    end
  end

  assign w_hs       = (r_state == c_IDLE) && w_found;
  assign w_ptr_nxt  = (w_gnt == c_PTR_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
  assign w_gnt_err  = ({1'b0, w_gnt_idx} >= c_WIDTH);
  assign w_rsp_fire = (r_state == c_SETTLE) && (r_cnt == '0);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && w_hs && (w_gnt == c_PTR_W'(i));
    end
  end

  always_comb begin
    w_q_sel = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (r_idx == IDX_W'(b)) begin
        w_q_sel = jk_q[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_hs) w_state_nxt = c_DRIVE;
      c_DRIVE:  w_state_nxt = c_SETTLE;
      c_SETTLE: if (r_cnt == '0) w_state_nxt = c_RESP;
      c_RESP:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the registered outputs; the pulse is launched on the handshake
  // edge so the cell sees it for exactly the DRIVE cycle.
  always_comb begin
    w_jk_j_nxt      = '0;
    w_jk_k_nxt      = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_q_nxt     = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (w_hs && (w_gnt_idx == IDX_W'(b))) begin
        w_jk_j_nxt[b] = w_gnt_op[1];
        w_jk_k_nxt[b] = w_gnt_op[0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_valid_nxt[i] = w_rsp_fire && (r_gnt == c_PTR_W'(i));
    end
    if (w_rsp_fire) begin
      w_rsp_q_nxt   = r_err ? 1'b0 : w_q_sel;
      w_rsp_err_nxt = r_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_jk_j      <= '0;
      r_jk_k      <= '0;
      r_rsp_valid <= '0;
      r_rsp_q     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_gnt <= w_gnt;
        r_idx <= w_gnt_idx;
        r_err <= w_gnt_err;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == c_DRIVE) begin
        r_cnt <= c_CNT_INIT;
      end else if ((r_state == c_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_jk_j      <= w_jk_j_nxt;
      r_jk_k      <= w_jk_k_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= (w_state_nxt != c_IDLE);
    end
  end

  assign jk_j      = r_jk_j;
  assign jk_k      = r_jk_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_q     = r_rsp_q;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// tb_jk_bank_arbiter: directed and randomized requests checked against a
// round-robin / JK truth-table reference model, with a behavioural cell bank.

module tb_jk_bank_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 8;
  localparam int IDX_W = 4;
  localparam int S     = 2;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op  = '0;
  logic [IDX_W*NREQ-1:0] req_idx = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_q;
  logic                  rsp_err;
  logic                  busy;
  logic [WIDTH-1:0]      jk_j;
  logic [WIDTH-1:0]      jk_k;
  logic [WIDTH-1:0]      cell_q = '0;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int               ptr_m = 0;
  bit               ref_q [WIDTH];
  logic [1:0]       t_op  [NREQ];
  logic [IDX_W-1:0] t_idx [NREQ];
  int               glitch_req = -1;

  always #5 clk = ~clk;

  jk_bank_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .IDX_W(IDX_W), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy),
    .jk_j(jk_j), .jk_k(jk_k), .jk_q(cell_q)
  );

  // External JK cell bank
  always @(posedge clk) begin
    for (int b = 0; b < WIDTH; b++) begin
      case ({jk_j[b], jk_k[b]})
        2'b01:   cell_q[b] <= 1'b0;
        2'b10:   cell_q[b] <= 1'b1;
        2'b11:   cell_q[b] <= ~cell_q[b];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_rspv"},  32'(rsp_valid), 32'(0));
    check({tag, "_rspq"},  32'(rsp_q),     32'(0));
    check({tag, "_rspe"},  32'(rsp_err),   32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_j"},     32'(jk_j),      32'(0));
    check({tag, "_k"},     32'(jk_k),      32'(0));
  endtask

  function automatic int pick(input logic [NREQ-1:0] pend);
    for (int off = 0; off < NREQ; off++) begin
      if (pend[(ptr_m + off) % NREQ]) return (ptr_m + off) % NREQ;
    end
    return 0;
  endfunction

  // Present the requests in mask and follow every transaction to completion.
  // rst_at >= 0 pulses reset at that many cycles after the handshake.
  task automatic serve(input logic [NREQ-1:0] mask, input int rst_at);
    logic [NREQ-1:0]  pend;
    logic [WIDTH-1:0] ej, ek;
    logic             err, eq;
    int               g, w, ix;
    pend = mask;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_valid[i]               = 1'b1;
        req_op[2*i +: 2]           = t_op[i];
        req_idx[IDX_W*i +: IDX_W]  = t_idx[i];
      end
    end
    while (pend != '0) begin
      g = pick(pend);
      #1;
      w = 0;
      while (req_ready == '0 && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      check("ready_grant", 32'(req_ready), 32'(1 << g));
      if (req_ready == '0) begin
        req_valid = '0;
        return;
      end
      @(posedge clk);
      ptr_m = (g + 1) % NREQ;
      ix    = int'(t_idx[g]);
      err   = (ix >= WIDTH);
      ej    = '0;
      ek    = '0;
      eq    = 1'b0;
      if (!err) begin
        ej = WIDTH'(t_op[g][1]) << ix;
        ek = WIDTH'(t_op[g][0]) << ix;
        case (t_op[g])
          2'b01:   ref_q[ix] = 1'b0;
          2'b10:   ref_q[ix] = 1'b1;
          2'b11:   ref_q[ix] = ~ref_q[ix];
          default: ;
        endcase
        eq = ref_q[ix];
      end
      for (int k = 0; k <= S + 2; k++) begin
        @(negedge clk);
        if (k == rst_at) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("rst_mid");
          ptr_m     = 0;
          req_valid = '0;
          @(negedge clk);
          rst_n = 1'b1;
          for (int c = 0; c < S + 3; c++) begin
            @(negedge clk);
            check("post_rst_rspv", 32'(rsp_valid), 32'(0));
            check("post_rst_busy", 32'(busy), 32'(0));
          end
          return;
        end
        check("jk_j", 32'(jk_j), 32'(k == 0 ? ej : '0));
        check("jk_k", 32'(jk_k), 32'(k == 0 ? ek : '0));
        check("busy", 32'(busy), 32'(k <= S + 1));
        check("rsp_valid", 32'(rsp_valid), 32'(k == S + 1 ? (1 << g) : 0));
        if (k <= S + 1) check("ready_busy", 32'(req_ready), 32'(0));
        if (k == S + 1) begin
          check("rsp_q", 32'(rsp_q), 32'(eq));
          check("rsp_err", 32'(rsp_err), 32'(err));
        end
        if (glitch_req >= 0 && k == 1)     req_valid[glitch_req] = 1'b1;
        if (glitch_req >= 0 && k == S + 1) req_valid[glitch_req] = 1'b0;
        if (k == 0) begin
          req_valid[g]               = 1'b0;
          pend[g]                    = 1'b0;
          req_op[2*g +: 2]           = 2'($urandom);
          req_idx[IDX_W*g +: IDX_W]  = IDX_W'($urandom);
        end
      end
    end
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted
    #2;
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // Set idx 3 from requester 0
    t_op[0] = 2'b10; t_idx[0] = 4'd3;
    serve(3'b001, -1);

    // Toggle idx 5 three times: 1,0,1
    t_op[1] = 2'b11; t_idx[1] = 4'd5;
    for (int n = 0; n < 3; n++) serve(3'b010, -1);

    // Bring pointer back to 0, then alternate 0,1,0,1
    t_op[2] = 2'b00; t_idx[2] = 4'd7;
    serve(3'b100, -1);
    t_op[0] = 2'b10; t_idx[0] = 4'd1;
    t_op[1] = 2'b11; t_idx[1] = 4'd2;
    serve(3'b011, -1);
    serve(3'b011, -1);

    // Out-of-range index
    t_op[0] = 2'b11; t_idx[0] = 4'd9;
    serve(3'b001, -1);

    // Requester 2 raises and drops valid while busy: no grant, pointer kept
    glitch_req = 2;
    t_op[0] = 2'b00; t_idx[0] = 4'd0;
    serve(3'b001, -1);
    glitch_req = -1;
    t_op[0] = 2'b10; t_idx[0] = 4'd0;
    t_op[2] = 2'b10; t_idx[2] = 4'd7;
    serve(3'b101, -1);

    // Set, clear, then hold on idx 4
    t_op[1] = 2'b10; t_idx[1] = 4'd4;
    serve(3'b010, -1);
    t_op[1] = 2'b01;
    serve(3'b010, -1);
    t_op[1] = 2'b00;
    serve(3'b010, -1);

    // Reset during SETTLE, then requester 0 wins a contended grant
    t_op[0] = 2'b10; t_idx[0] = 4'd6;
    serve(3'b001, 1);
    t_op[0] = 2'b00; t_idx[0] = 4'd6;
    t_op[1] = 2'b11; t_idx[1] = 4'd6;
    serve(3'b011, -1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        t_op[i]  = 2'($urandom);
        t_idx[i] = IDX_W'($urandom_range(0, 10));
      end
      serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
